// File: rtl/pipe_skid_buf_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_skid_buf_if
// Description : Valid/ready handshake bundle for pipe_skid_buf. It carries
//               the upstream side (in_*) and the downstream side (out_*).
//   Signals:
//     in_valid  - upstream data valid
//     in_data   - upstream payload, DWIDTH bits
//     in_ready  - buffer can accept this cycle (registered in the buffer)
//     out_valid - downstream data valid (registered in the buffer)
//     out_data  - downstream payload (registered in the buffer)
//     out_ready - downstream accepts this cycle
//   Modports:
//     master - the environment: drives in_valid/in_data/out_ready
//     slave  - the buffer: drives in_ready/out_valid/out_data
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_skid_buf_if #(
  parameter int DWIDTH = 8
);
  logic              in_valid;
  logic [DWIDTH-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DWIDTH-1:0] out_data;
  logic              out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface
`default_nettype wire

// File: rtl/pipe_skid_buf.sv
`default_nettype none
// ============================================================================
// Module      : pipe_skid_buf
// Description : Valid/ready register slice with a one-entry skid register.
//               It breaks the combinational path on data/valid and on ready
//               while sustaining one word per cycle.
//   Ports:
//     clk   - rising-edge clock
//     rst   - synchronous reset, active-high; overrides everything
//     flush - synchronous clear of buffered contents (valid bits only)
//     bus   - handshake bundle (slave modport of pipe_skid_buf_if)
//     count - entries held: 0, 1 or 2 (registered)
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_skid_buf #(
  parameter int DWIDTH = 8
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        flush,
  pipe_skid_buf_if.slave   bus,
  output logic [1:0]       count
);

  // State is carried by the two valid bits: {skid, main}.
  localparam logic [1:0] C_EMPTY = 2'b00;
  localparam logic [1:0] C_ONE   = 2'b01;
  localparam logic [1:0] C_TWO   = 2'b11;

  logic              main_valid_q, main_valid_d;
  logic [DWIDTH-1:0] main_data_q,  main_data_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DWIDTH-1:0] skid_data_q,  skid_data_d;
  logic [1:0]        count_q,      count_d;

  logic w_in_ready;
  logic w_in_fire;
  logic w_out_fire;

  // Ready comes only from the skid flop, never from out_ready.
  assign w_in_ready = ~skid_valid_q;
  assign w_in_fire  = bus.in_valid & w_in_ready;
  assign w_out_fire = main_valid_q & bus.out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;

    if (flush) begin
      // Data registers keep stale contents; only occupancy is cleared.
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      case ({skid_valid_q, main_valid_q})
        C_EMPTY: begin
          if (w_in_fire) begin
            main_valid_d = 1'b1;
            main_data_d  = bus.in_data;
          end
        end
        C_ONE: begin
          if (w_in_fire && w_out_fire) begin
            main_data_d = bus.in_data;
          end else if (w_in_fire) begin
            skid_valid_d = 1'b1;
            skid_data_d  = bus.in_data;
          end else if (w_out_fire) begin
            main_valid_d = 1'b0;
          end
        end
        C_TWO: begin
          // in_ready is low here, so only the drain side can move.
          if (w_out_fire) begin
            main_data_d  = skid_data_q;
            skid_valid_d = 1'b0;
          end
        end
        default: begin
          // Unreachable encoding; recover to EMPTY.
          main_valid_d = 1'b0;
          skid_valid_d = 1'b0;
        end
      endcase
    end

    count_d = {1'b0, main_valid_d} + {1'b0, skid_valid_d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      count_q      <= 2'd0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      count_q      <= count_d;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = main_valid_q;
  assign bus.out_data  = main_data_q;
  assign count         = count_q;

endmodule
`default_nettype wire
